// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the seven-segment display multiplexer.
//   - Active-low segment patterns, ordered {g,f,e,d,c,b,a}.
//   - Digit slot indices. The slot index also selects the anode bit.
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;

    localparam logic [1:0] DIG_ONES  = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_HUND  = 2'd2;
    localparam logic [1:0] DIG_SIGN  = 2'd3;

endpackage

// File: rtl/seg_decoder.sv
// ----------------------------------------------------------------------------
// seg_decoder
// Purely combinational decoder from a 4-bit BCD code to an active-low
// segment pattern. Codes 10..15 are not valid BCD and display "E".
// Ports:
//   i_code  in  4  BCD code
//   o_seg   out 7  segments {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_E;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// ----------------------------------------------------------------------------
// seg_display_mux
// Time-multiplexed 4-digit common-anode seven-segment driver. One digit is
// scanned per slot of SCAN_DIV cycles; the first GUARD cycles of each slot
// keep all anodes off to suppress ghosting. All inputs are snapshotted once
// per frame (at the slot 3 -> slot 0 wrap) so a frame is always coherent.
// Supports leading-zero blanking and a blinking cursor with decimal point.
// Ports:
//   clk          in  1  system clock
//   reset        in  1  asynchronous, active-high
//   ones_in      in  4  BCD ones digit
//   tens_in      in  4  BCD tens digit
//   hundreds_in  in  4  BCD hundreds digit
//   sign_in      in  1  1 = negative
//   blank_lz     in  1  leading-zero blanking enable
//   cursor_en    in  1  cursor enable
//   cursor_pos   in  2  cursor digit (0 ones, 1 tens, 2 hundreds, 3 sign)
//   seg_n        out 7  segments {g,f,e,d,c,b,a}, active-low
//   dp_n         out 1  decimal point, active-low
//   an_n         out 4  anodes, active-low; an_n[k] selects digit k
// ----------------------------------------------------------------------------
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100_000,
    parameter int GUARD     = 1_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ones_in,
    input  logic [3:0] tens_in,
    input  logic [3:0] hundreds_in,
    input  logic       sign_in,
    input  logic       blank_lz,
    input  logic       cursor_en,
    input  logic [1:0] cursor_pos,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_digit_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;

    // Frame snapshot of every input
    logic [3:0]    r_ones;
    logic [3:0]    r_tens;
    logic [3:0]    r_hund;
    logic          r_sign;
    logic          r_blank_lz;
    logic          r_cursor_en;
    logic [1:0]    r_cursor_pos;

    logic          w_scan_wrap;
    logic          w_frame_wrap;
    logic [3:0]    w_code;
    logic [6:0]    w_dec_seg;
    logic          w_lz_blank;
    logic          w_cursor_here;
    logic          w_guard;
    logic [3:0]    w_an_sel;
    logic [6:0]    w_seg_next;

    assign w_scan_wrap  = (r_scan_cnt == SW'(SCAN_DIV - 1));
    assign w_frame_wrap = w_scan_wrap && (r_digit_idx == DIG_SIGN);
    assign w_guard      = (r_scan_cnt < SW'(GUARD));

    // Slot mux feeding the single shared decoder; the sign slot does not
    // use the decoder so its code is a don't-care.
    always_comb begin
        w_code = 4'd0;
        case (r_digit_idx)
            DIG_ONES: w_code = r_ones;
            DIG_TENS: w_code = r_tens;
            DIG_HUND: w_code = r_hund;
            default:  w_code = 4'd0;
        endcase
    end

    seg_decoder u_dec (
        .i_code (w_code),
        .o_seg  (w_dec_seg)
    );

    // Tens is only a leading zero when hundreds is also zero.
    assign w_lz_blank = r_blank_lz &&
                        (((r_digit_idx == DIG_HUND) && (r_hund == 4'd0)) ||
                         ((r_digit_idx == DIG_TENS) && (r_hund == 4'd0) &&
                          (r_tens == 4'd0)));

    assign w_cursor_here = r_cursor_en && (r_cursor_pos == r_digit_idx);

    // One-hot active-low anode select for the current slot
    for (genvar gi = 0; gi < 4; gi++) begin : g_an
        assign w_an_sel[gi] = (r_digit_idx != 2'(gi));
    end

    // Blink-off blank beats leading-zero blank beats normal content.
    always_comb begin
        w_seg_next = w_dec_seg;
        if (w_cursor_here && !r_blink_on)
            w_seg_next = SEG_BLANK;
        else if (r_digit_idx == DIG_SIGN)
            w_seg_next = r_sign ? SEG_MINUS : SEG_BLANK;
        else if (w_lz_blank)
            w_seg_next = SEG_BLANK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt   <= '0;
            r_digit_idx  <= DIG_ONES;
            r_blink_cnt  <= '0;
            r_blink_on   <= 1'b1;
            r_ones       <= '0;
            r_tens       <= '0;
            r_hund       <= '0;
            r_sign       <= 1'b0;
            r_blank_lz   <= 1'b0;
            r_cursor_en  <= 1'b0;
            r_cursor_pos <= '0;
            seg_n        <= SEG_BLANK;
            dp_n         <= 1'b1;
            an_n         <= 4'hF;
        end else begin
            if (w_scan_wrap) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_scan_cnt  <= r_scan_cnt + SW'(1);
            end

            if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end

            if (w_frame_wrap) begin
                r_ones       <= ones_in;
                r_tens       <= tens_in;
                r_hund       <= hundreds_in;
                r_sign       <= sign_in;
                r_blank_lz   <= blank_lz;
                r_cursor_en  <= cursor_en;
                r_cursor_pos <= cursor_pos;
            end

            seg_n <= w_seg_next;
            dp_n  <= ~w_cursor_here;
            an_n  <= w_guard ? 4'hF : w_an_sel;
        end
    end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Time-multiplexed 4-digit seven-segment driver. It sits directly downstream of the operand entry stage.
- Consumes the entered BCD digits (ones/tens/hundreds) and the sign flag, and drives the board's common-anode display.
- Scans one digit per slot and latches a coherent snapshot of the inputs once per frame.
- Supports leading-zero blanking, a blinking cursor digit with a decimal-point marker, and ghost-suppression guard time.

Parameters:
- SCAN_DIV, 100_000: clk cycles per digit slot (1 kHz per digit at 100 MHz).
- GUARD, 1_000: cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high.
- ones_in  in  4  BCD ones digit.
- tens_in  in  4  BCD tens digit.
- hundreds_in  in  4  BCD hundreds digit.
- sign_in  in  1  1 = negative.
- blank_lz  in  1  enables leading-zero blanking.
- cursor_en  in  1  enables the cursor.
- cursor_pos  in  2  cursor digit: 0 ones, 1 tens, 2 hundreds, 3 sign.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  4  anodes, active-low; an_n[k] selects digit k.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - Outputs: seg_n=7'h7F, dp_n=1, an_n=4'hF.
  - Internal: scan_cnt=0, digit_idx=0, blink_cnt=0, blink_on=1, all shadow registers 0.
  - Reset asserted mid-slot forces outputs to these values immediately. Scanning restarts at slot 0, cycle 0, after deassertion.
- Scan counter: scan_cnt runs 0..SCAN_DIV-1 and wraps. On wrap, digit_idx advances 0→1→2→3→0.
- Snapshot: on the wrap where digit_idx goes 3→0, all inputs (digits, sign, blank_lz, cursor_en, cursor_pos) are captured into shadow registers. Input changes mid-frame are not displayed until the next frame.
- Outputs are registered. They reflect digit_idx and scan_cnt with 1 cycle latency.
- Guard: while scan_cnt < GUARD, an_n=4'hF. Otherwise an_n has the single bit digit_idx low.
- Digit content:
  - Slot 0: ones. Slot 1: tens. Slot 2: hundreds.
  - Slot 3: minus sign (7'h3F) when sign=1, blank (7'h7F) when sign=0.
- Decode, seg_n values:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
  - Codes 10–15 → 06 ("E").
- Leading-zero blanking (shadow blank_lz=1):
  - hundreds blank when hundreds==0.
  - tens blank when hundreds==0 and tens==0.
  - ones is never blanked.
  - Blanked digits: seg_n=7'h7F, anode still driven.
- Blink: blink_cnt counts 0..BLINK_DIV-1; blink_on toggles on each wrap.
- Cursor (shadow cursor_en=1):
  - In the slot equal to cursor_pos, dp_n=0 in both blink phases.
  - While blink_on=0, that slot's seg_n=7'h7F.
  - dp_n=1 in all other slots, and whenever the cursor is disabled.
- Priority for the cursor slot: blink-off blank > leading-zero blank > decode.

Decomposition:
- Package seg_pkg holds:
  - Segment pattern constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK, SEG_E.
  - Digit index constants DIG_ONES, DIG_TENS, DIG_HUND, DIG_SIGN.
- Sub-module seg_decoder: combinational 4-bit code → 7-bit seg_n. Instantiated once, fed by the slot mux.
- Counters, snapshot, blanking and cursor logic stay in the top module.

Test Plan:
All scenarios use SCAN_DIV=8, GUARD=2, BLINK_DIV=64.
- Reset asserted mid-slot 2 → seg_n=7F, dp_n=1, an_n=F without a clk edge. After release, the first active slot is 0 at scan_cnt=2 (+1 cycle latency).
- ones=3, tens=2, hundreds=1, sign=1, blank_lz=0 → per slot after guard: an_n=E/seg 30; D/24; B/79; 7/3F. an_n=F during the first 2 cycles of each slot.
- blank_lz=1, hundreds=0, tens=0, ones=7, sign=0 → slot 0 seg 78; slots 1–3 seg 7F. With tens=5 instead: slot 1 seg 12, slot 2 seg 7F.
- Change ones 3→8 during slot 1 → slots 1–3 of that frame unchanged. Slot 0 shows 30 until the frame wrap, then 00 in the next frame.
- cursor_en=1, cursor_pos=1, tens=4 → slot 1 dp_n=0 in both phases; seg 19 while blink_on=1, 7F while blink_on=0; phase flips every 64 cycles. Other slots dp_n=1.
- ones_in=4'd12 → slot 0 seg 06. hundreds_in=4'd15 with blank_lz=1 → slot 2 seg 06 (non-zero, so not blanked).
